alu_ctrl: RTL
=============

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 4, meaning the register file entry count (fixed at 4; index fields are 2 bits).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  instruction present.
REQ-005 SHALL have port in_ready  out  1  controller can accept an instruction.
REQ-006 SHALL have port in_instr  in  10  the instruction: [9]=imm, [8:6]=opcode, [5:4]=rd, [3:2]=ra, [1:0]=rb.
REQ-007 SHALL have port in_imm  in  8  immediate value, sampled with in_instr.
REQ-008 SHALL have port alu_a  out  8  operand A to the external 8-bit ALU.
REQ-009 SHALL have port alu_b  out  8  operand B to the external ALU.
REQ-010 SHALL have port alu_op  out  3  opcode to the external ALU.
REQ-011 SHALL have port alu_out  in  8  combinational ALU result.
REQ-012 SHALL have port out_valid  out  1  result available.
REQ-013 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-014 SHALL have port out_data  out  8  result value written to rd.
REQ-015 SHALL have port out_rd  out  2  destination register index of the result.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 In IDLE: in_ready=1; in_valid&in_ready latches in_instr and in_imm and moves to EXEC; otherwise stays in IDLE.
REQ-018 In EXEC (exactly 1 cycle): alu_a=reg[ra], alu_b=reg[rb], alu_op=opcode.
REQ-019 At the end of EXEC: result=imm ? in_imm (latched) : alu_out; reg[rd] and out_data are written with result; state moves to RESP.
REQ-020 Outside EXEC: alu_a, alu_b and alu_op SHALL be driven 0.
REQ-021 In RESP: out_valid=1, with out_data and out_rd held stable; out_valid&out_ready returns to IDLE.
REQ-022 in_ready SHALL be 0 in EXEC and RESP; no instruction is accepted until the response is consumed.
REQ-023 Latency: accept at edge N; out_valid high in the cycle after edge N+1; minimum 3 cycles per instruction.
REQ-024 ra==rb, rd==ra and rd==rb SHALL be legal; operands are read before the write.
REQ-025 The result width SHALL be 8 bits, taken as-is from the ALU; opcode 111 passes through unchanged (the ALU returns 0).
REQ-026 When the imm bit is set, the ALU bus is still driven in EXEC but its result is ignored.

Reset
REQ-027 When rst=1, the next edge SHALL: set state=IDLE; clear all regs, out_data and out_rd to 0; set out_valid=0 and in_ready=1 after reset.
REQ-028 A reset asserted during EXEC or RESP SHALL abort the operation: no register write and no response.

Configuration
REQ-029 Macro ALU_CTRL_ZFLAG_EN defined: adds output out_zero (1 bit), registered with out_data, equal to 1 when the result is 0x00, and reset to 0.
REQ-030 Macro ALU_CTRL_ZFLAG_EN undefined: the out_zero port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package alu_pkg SHALL hold the opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, MUL4=110), the instruction field offsets and the FSM state typedef.
REQ-032 The register file SHALL be a sub-module alu_regfile (4x8, two combinational read ports, one synchronous write port, synchronous reset clear).
REQ-033 The ALU itself SHALL stay external; alu_ctrl only drives and samples it.

Verification
REQ-034 Reset then load imm 0x05 to r1 -> out_data=0x05, out_rd=1; r1 reads 5 in the next instruction.
REQ-035 r1=0x05, r2=0x03, ADD rd=3 -> alu_a=0x05, alu_b=0x03, alu_op=000 in EXEC; out_data=0x08; SUB gives 0x02.
REQ-036 r1=0x03, SUB r0=r2-r1 with r2=0x00 -> out_data=0xFD (wrap-around).
REQ-037 Hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid, out_data and out_rd stay stable, in_ready=0, and the second instruction is not accepted until the handshake completes.
REQ-038 Assert rst during EXEC of ADD r1=r1+r1 -> no response, r1=0, in_ready=1 after reset.
REQ-039 With ALU_CTRL_ZFLAG_EN defined, XOR r2=r1^r1 -> out_data=0x00, out_zero=1; ADD giving 0x08 -> out_zero=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: opcodes, instruction field layout, FSM states.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 10;
    localparam int IDX_W   = 2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_MUL4 = 3'b110;

    // Instruction layout: [9]=imm, [8:6]=opcode, [5:4]=rd, [3:2]=ra, [1:0]=rb
    localparam int IMM_BIT = 9;
    localparam int OP_LSB  = 6;
    localparam int RD_LSB  = 4;
    localparam int RA_LSB  = 2;
    localparam int RB_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one synchronous write port,
// synchronous clear on rst.
module alu_regfile #(
    parameter int NREG = 4,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] ra_addr,
    output logic [W-1:0]            ra_data,
    input  logic [$clog2(NREG)-1:0] rb_addr,
    output logic [W-1:0]            rb_data,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wr_addr,
    input  logic [W-1:0]            wr_data
);
    localparam int AW = $clog2(NREG);

    logic [W-1:0] mem_reg [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (we && (wr_addr == AW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign ra_data = mem_reg[ra_addr];
    assign rb_data = mem_reg[rb_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing controller for an external 8-bit ALU (accept -> execute -> respond).
// Optional zero flag output enabled by defining ALU_CTRL_ZFLAG_EN.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [DATA_W-1:0]    in_imm,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [2:0]           alu_op,
    input  logic [DATA_W-1:0]    alu_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [IDX_W-1:0]     out_rd
`ifdef ALU_CTRL_ZFLAG_EN
    ,
    output logic                 out_zero
`endif
);

    state_t             state_reg, state_next;
    logic [INSTR_W-1:0] instr_reg;
    logic [DATA_W-1:0]  imm_reg;
    logic [DATA_W-1:0]  out_data_reg;
    logic [IDX_W-1:0]   out_rd_reg;
    logic               wr_en;
    logic [DATA_W-1:0]  result;
    logic [DATA_W-1:0]  ra_data, rb_data;

    logic [IDX_W-1:0] rd_idx, ra_idx, rb_idx;
    logic [2:0]       op_field;

    assign rd_idx   = instr_reg[RD_LSB +: IDX_W];
    assign ra_idx   = instr_reg[RA_LSB +: IDX_W];
    assign rb_idx   = instr_reg[RB_LSB +: IDX_W];
    assign op_field = instr_reg[OP_LSB +: 3];

    // Immediate loads still drive the ALU bus; only the captured result changes source.
    assign result = instr_reg[IMM_BIT] ? imm_reg : alu_out;

    alu_regfile #(
        .NREG (NREG),
        .W    (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ra_idx),
        .ra_data (ra_data),
        .rb_addr (rb_idx),
        .rb_data (rb_data),
        .we      (wr_en),
        .wr_addr (rd_idx),
        .wr_data (result)
    );

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                alu_a      = ra_data;
                alu_b      = rb_data;
                alu_op     = op_field;
                wr_en      = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            instr_reg    <= '0;
            imm_reg      <= '0;
            out_data_reg <= '0;
            out_rd_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                instr_reg <= in_instr;
                imm_reg   <= in_imm;
            end
            if (wr_en) begin
                out_data_reg <= result;
                out_rd_reg   <= rd_idx;
            end
        end
    end

    assign out_data = out_data_reg;
    assign out_rd   = out_rd_reg;

`ifdef ALU_CTRL_ZFLAG_EN
    logic out_zero_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero_reg <= 1'b0;
        end else if (wr_en) begin
            out_zero_reg <= (result == '0);
        end
    end

    assign out_zero = out_zero_reg;
`else
`endif

endmodule
